// File: rtl/tsc_check_pkg.sv
// Shared types and constants for the two-rail checker controller: FSM states,
// sizes, and the self-test vector table with its expected checker verdicts.
package tsc_check_pkg;

    typedef enum logic [1:0] {
        MON   = 2'd0,
        T_DRV = 2'd1,
        T_CHK = 2'd2,
        T_END = 2'd3
    } state_e;

    localparam int NUM_VEC   = 5;
    localparam int ERR_CNT_W = 8;
    localparam int VEC_IDX_W = 3;
    localparam int WORD_W    = 16;

    // Each entry packs {x0, x1, y0, y1}; V4 breaks the x0/y0 pair on purpose.
    localparam logic [4*WORD_W-1:0] VEC_TABLE [NUM_VEC] = '{
        {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF},
        {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000},
        {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF},
        {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},
        {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}
    };

    // Bit i set means vector i must make the tree report an error (f == g).
    localparam logic [NUM_VEC-1:0] VEC_EXP_ERR = 5'b10000;

endpackage

// File: rtl/tsc_test_rom.sv
// Maps a self-test vector index to the dual-rail words and expected verdict.
// Out-of-range indices return all-zero words and no expected error.
module tsc_test_rom
    import tsc_check_pkg::*;
(
    input  logic [VEC_IDX_W-1:0] idx_i,
    output logic [WORD_W-1:0]    x0_o,
    output logic [WORD_W-1:0]    x1_o,
    output logic [WORD_W-1:0]    y0_o,
    output logic [WORD_W-1:0]    y1_o,
    output logic                 exp_err_o
);

    always_comb begin
        x0_o      = '0;
        x1_o      = '0;
        y0_o      = '0;
        y1_o      = '0;
        exp_err_o = 1'b0;
        if (idx_i < VEC_IDX_W'(NUM_VEC)) begin
            {x0_o, x1_o, y0_o, y1_o} = VEC_TABLE[idx_i];
            exp_err_o                = VEC_EXP_ERR[idx_i];
        end
    end

endmodule

// File: rtl/tsc_check_ctrl.sv
// Drives a 16-bit two-rail checker tree with functional words or a built-in
// self-test sequence, and tracks functional errors in a sticky flag/counter.
module tsc_check_ctrl
    import tsc_check_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_W-1:0]    din_x0,
    input  logic [WORD_W-1:0]    din_x1,
    input  logic [WORD_W-1:0]    din_y0,
    input  logic [WORD_W-1:0]    din_y1,
    input  logic                 din_valid,
    output logic [WORD_W-1:0]    chk_x0,
    output logic [WORD_W-1:0]    chk_x1,
    output logic [WORD_W-1:0]    chk_y0,
    output logic [WORD_W-1:0]    chk_y1,
    input  logic                 chk_f,
    input  logic                 chk_g,
    input  logic                 start_test,
    input  logic                 clear_err,
    output logic                 busy,
    output logic                 test_done,
    output logic                 test_pass,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count,
    output state_e               dbg_state
);

    state_e                 state_q, state_d;
    logic [VEC_IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]      x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic                   sample_q, sample_d;
    logic                   mism_q, mism_d;
    logic                   pass_q, pass_d;
    logic                   err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WORD_W-1:0]      rom_x0, rom_x1, rom_y0, rom_y1;
    logic                   rom_exp_err;
    logic                   tree_err;
    logic                   func_err;
    logic                   vec_mism;

    tsc_test_rom u_rom (
        .idx_i     (idx_q),
        .x0_o      (rom_x0),
        .x1_o      (rom_x1),
        .y0_o      (rom_y0),
        .y1_o      (rom_y1),
        .exp_err_o (rom_exp_err)
    );

    assign tree_err = (chk_f == chk_g);
    assign vec_mism = (tree_err != rom_exp_err);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        sample_d   = sample_q;
        mism_d     = mism_q;
        pass_d     = pass_q;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        func_err   = 1'b0;

        unique case (state_q)
            MON: begin
                // A test request wins over functional data and drops any pending sample.
                if (start_test) begin
                    state_d  = T_DRV;
                    idx_d    = '0;
                    pass_d   = 1'b0;
                    mism_d   = 1'b0;
                    sample_d = 1'b0;
                end else begin
                    func_err = sample_q && tree_err;
                    sample_d = din_valid;
                    if (din_valid) begin
                        x0_d = din_x0;
                        x1_d = din_x1;
                        y0_d = din_y0;
                        y1_d = din_y1;
                    end
                end
            end
            T_DRV: begin
                x0_d    = rom_x0;
                x1_d    = rom_x1;
                y0_d    = rom_y0;
                y1_d    = rom_y1;
                state_d = T_CHK;
            end
            T_CHK: begin
                mism_d = mism_q | vec_mism;
                if (idx_q == VEC_IDX_W'(NUM_VEC - 1)) begin
                    state_d = T_END;
                    pass_d  = !(mism_q | vec_mism);
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = T_DRV;
                end
            end
            T_END: begin
                state_d = MON;
                idx_d   = '0;
            end
            default: state_d = MON;
        endcase

        // A detected error outranks a same-cycle clear and restarts the count at 1.
        if (func_err) begin
            err_flag_d = 1'b1;
            if (clear_err) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (clear_err) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MON;
            idx_q      <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            sample_q   <= 1'b0;
            mism_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            sample_q   <= sample_d;
            mism_q     <= mism_d;
            pass_q     <= pass_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign chk_x0    = x0_q;
    assign chk_x1    = x1_q;
    assign chk_y0    = y0_q;
    assign chk_y1    = y1_q;
    assign busy      = (state_q != MON);
    assign test_done = (state_q == T_END);
    assign test_pass = pass_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tsc_check_ctrl.sv
// Directed bench for tsc_check_ctrl with a behavioural two-rail checker model
// that can also be forced to fixed f/g values.
module tb_tsc_check_ctrl;
    import tsc_check_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_x0, din_x1, din_y0, din_y1;
    logic        din_valid;
    logic [15:0] chk_x0, chk_x1, chk_y0, chk_y1;
    logic        chk_f, chk_g;
    logic        start_test, clear_err;
    logic        busy, test_done, test_pass, err_flag;
    logic [7:0]  err_count;
    state_e      dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int mode  = 0;  // 0: good tree, 1: forced f=g=1, 2: stuck f=0 g=1

    always #5 clk = ~clk;

    tsc_check_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_x0     (din_x0),
        .din_x1     (din_x1),
        .din_y0     (din_y0),
        .din_y1     (din_y1),
        .din_valid  (din_valid),
        .chk_x0     (chk_x0),
        .chk_x1     (chk_x1),
        .chk_y0     (chk_y0),
        .chk_y1     (chk_y1),
        .chk_f      (chk_f),
        .chk_g      (chk_g),
        .start_test (start_test),
        .clear_err  (clear_err),
        .busy       (busy),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .err_flag   (err_flag),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    always_comb begin
        chk_f = 1'b0;
        chk_g = 1'b0;
        case (mode)
            0: chk_g = (&(chk_x0 ^ chk_y0)) & (&(chk_x1 ^ chk_y1));
            1: begin chk_f = 1'b1; chk_g = 1'b1; end
            default: chk_g = 1'b1;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic v, input logic [15:0] x0, input logic [15:0] y0,
                              input logic [15:0] x1, input logic [15:0] y1);
        din_valid = v;
        din_x0 = x0;
        din_y0 = y0;
        din_x1 = x1;
        din_y1 = y1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_chk"}, {chk_x0 | chk_x1 | chk_y0 | chk_y1}, 32'h0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, test_done, 0);
        check_eq({tag, "_pass"}, test_pass, 0);
        check_eq({tag, "_flag"}, err_flag, 0);
        check_eq({tag, "_cnt"}, err_count, 0);
        check_eq({tag, "_state"}, dbg_state, MON);
    endtask

    // Issues start_test, then steps until test_done; returns the cycle it appeared.
    task automatic run_test(input bit poke_start, output int n);
        int busy_low;
        busy_low = 0;
        start_test = 1'b1;
        step();
        start_test = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_pass_clr", test_pass, 0);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            start_test = (poke_start && i == 3);
            step();
            if (!busy) busy_low++;
            if (test_done) begin
                n = i;
                break;
            end
        end
        start_test = 1'b0;
        check_eq("test_busy_held", busy_low, 0);
        check_eq("test_done_cycle", n, 10);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start_test = 1'b0;
        clear_err = 1'b0;
        drive_word(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        #12;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;

        // Valid code word with a healthy tree: no error.
        drive_word(1'b1, 16'h1234, 16'hEDCB, 16'h00FF, 16'hFF00);
        step();
        check_eq("load_x0", chk_x0, 16'h1234);
        check_eq("load_y1", chk_y1, 16'hFF00);
        drive_word(1'b0, 16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555);
        step();
        check_eq("code_cnt", err_count, 0);
        check_eq("code_flag", err_flag, 0);
        check_eq("hold_x1", chk_x1, 16'h00FF);
        check_eq("hold_y0", chk_y0, 16'hEDCB);

        // Three words with the tree forced to f = g.
        mode = 1;
        drive_word(1'b1, 16'h0001, 16'hFFFE, 16'h0, 16'hFFFF);
        step();
        check_eq("err3_pre", err_count, 0);
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive_word(1'b1, 16'(i), ~16'(i), 16'h0, 16'hFFFF);
            else din_valid = 1'b0;
            step();
            check_eq("err3_cnt", err_count, i);
            check_eq("err3_flag", err_flag, 1);
        end
        mode = 0;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("clear_cnt", err_count, 0);
        check_eq("clear_flag", err_flag, 0);

        // One functional error so the test can be shown not to touch the count.
        mode = 1;
        drive_word(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        din_valid = 1'b0;
        step();
        check_eq("pre_test_cnt", err_count, 1);
        mode = 0;

        // Self-test with a good tree; a second start mid-test is ignored.
        run_test(1'b1, n);
        check_eq("good_pass", test_pass, 1);
        check_eq("good_end_state", dbg_state, T_END);
        step();
        check_eq("good_busy_off", busy, 0);
        check_eq("good_done_off", test_done, 0);
        check_eq("good_pass_held", test_pass, 1);
        check_eq("good_cnt_kept", err_count, 1);
        check_eq("good_flag_kept", err_flag, 1);

        // Tree stuck at f=0 g=1: V4 cannot show its error.
        mode = 2;
        run_test(1'b0, n);
        check_eq("stuck_pass", test_pass, 0);
        step();
        check_eq("stuck_pass_held", test_pass, 0);
        check_eq("stuck_cnt_kept", err_count, 1);

        // Saturation: 300 errors, then clear colliding with an error.
        mode = 1;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("sat_pre", err_count, 0);
        drive_word(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 301; i++) step();
        check_eq("sat_cnt", err_count, 255);
        check_eq("sat_flag", err_flag, 1);
        clear_err = 1'b1;
        step();
        check_eq("clr_race_cnt", err_count, 1);
        check_eq("clr_race_flag", err_flag, 1);
        clear_err = 1'b0;
        din_valid = 1'b0;
        step();
        check_eq("after_race_cnt", err_count, 2);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("clear2_cnt", err_count, 0);

        // Reset during T_CHK of V2.
        drive_word(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        din_valid = 1'b0;
        step();
        check_eq("pre_rst_cnt", err_count, 1);
        mode = 0;
        start_test = 1'b1;
        step();
        start_test = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("v2_state", dbg_state, T_CHK);
        check_eq("v2_x0", chk_x0, 16'hFFFF);
        check_eq("v2_y1", chk_y1, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        rst_n = 1'b1;
        check_eq("post_rst_state", dbg_state, MON);
        run_test(1'b0, n);
        check_eq("post_rst_pass", test_pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
